// File: rtl/ring_slot_arbiter.sv
// Round-robin arbiter loading one registered ring slot from NUM_CLIENTS requesters,
// with a per-client burst limit and an observable EMPTY/FULL/STALL slot FSM.
module ring_slot_arbiter #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_CLIENTS-1:0]            i_req,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CLIENTS-1:0]            o_gnt,
  output logic                              o_valid,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic [$clog2(NUM_CLIENTS)-1:0]    o_src,
  input  logic                              i_ready
);

  localparam int unsigned PTR_W = $clog2(NUM_CLIENTS);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0]      src_q, src_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      last_src_q, last_src_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;

  logic                  accept;
  logic                  grant;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      win_next;
  logic [DATA_WIDTH-1:0] win_data;
  logic [CNT_W-1:0]      cnt_upd;
  int unsigned           idx;

  assign accept = (state_q == ST_EMPTY) | i_ready;

  // First requester at or after rr_ptr, searching upward modulo NUM_CLIENTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!win_found && i_req[PTR_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Reset gating makes the grant drop asynchronously with i_rst_n.
  assign grant = accept & win_found & i_rst_n;

  always_comb begin
    o_gnt = '0;
    if (grant) o_gnt[win_idx] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (win_idx == PTR_W'(k)) win_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign win_next = (win_idx == PTR_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + PTR_W'(1);

  // Slot FSM plus load, burst and pointer bookkeeping.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;
    cnt_upd     = '0;

    case (state_q)
      ST_EMPTY: begin
        if (grant) state_d = ST_FULL;
      end
      ST_FULL, ST_STALL: begin
        if (i_ready) state_d = grant ? ST_FULL : ST_EMPTY;
        else         state_d = ST_STALL;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (grant) begin
      data_d     = win_data;
      src_d      = win_idx;
      last_src_d = win_idx;
      if (win_idx == last_src_q && burst_cnt_q < CNT_W'(MAX_BURST)) cnt_upd = burst_cnt_q + CNT_W'(1);
      else                                                           cnt_upd = CNT_W'(1);
      // Burst exhausted: hand priority to the next index.
      if (cnt_upd == CNT_W'(MAX_BURST)) begin
        rr_ptr_d    = win_next;
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = win_idx;
        burst_cnt_d = cnt_upd;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_EMPTY;
      data_q      <= '0;
      src_q       <= '0;
      rr_ptr_q    <= '0;
      last_src_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      src_q       <= src_d;
      rr_ptr_q    <= rr_ptr_d;
      last_src_q  <= last_src_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign o_valid = (state_q != ST_EMPTY);
  assign o_data  = data_q;
  assign o_src   = src_q;

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// Directed bench for ring_slot_arbiter: reset, rotation, bursts, stalls, wrap and mid-run reset.
module tb_ring_slot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        valid;
  logic [7:0]  odata;
  logic [1:0]  src;
  logic        ready;

  int n_checks;
  int n_fail;

  ring_slot_arbiter #(.NUM_CLIENTS(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_data  (data),
    .o_gnt   (gnt),
    .o_valid (valid),
    .o_data  (odata),
    .o_src   (src),
    .i_ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] DATA_DEF = {8'h44, 8'h33, 8'h22, 8'h11};

  // Pulse reset between edges so every scenario starts from a known state.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = 4'b1111; ready = 1'b1; data = DATA_DEF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (odata !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", odata); end
    n_checks++; if (src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", src); end
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
  endtask

  task automatic test_rr_burst();
    logic [1:0] e;
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    req = 4'b1111; ready = 1'b1; data = DATA_DEF;
    for (int c = 0; c < 20; c++) begin
      e  = 2'((c / 4) % 4);
      eg = 4'b0001 << e;
      ed = 8'h11 * (8'(e) + 8'd1);
      #1;
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, eg); end
      step();
      n_checks++; if (src !== e) begin n_fail++; $display("FAIL rr_src[%0d]: got %0d expected %0d", c, src, e); end
      n_checks++; if (odata !== ed) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", c, odata, ed); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected 1", c, valid); end
    end
  endtask

  task automatic test_single_client();
    do_reset();
    req = 4'b0100; ready = 1'b1; data = DATA_DEF;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b expected 0100", c, gnt); end
      step();
      n_checks++; if (valid !== 1'b1 || src !== 2'd2) begin n_fail++; $display("FAIL single_slot[%0d]: got v=%b src=%0d expected v=1 src=2", c, valid, src); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    data = {8'h44, 8'h33, 8'hA5, 8'h11};
    req = 4'b0010; ready = 1'b1;
    step();
    n_checks++; if (valid !== 1'b1 || src !== 2'd1 || odata !== 8'hA5) begin n_fail++; $display("FAIL stall_load: got v=%b src=%0d d=%h expected v=1 src=1 d=a5", valid, src, odata); end
    ready = 1'b0; req = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b expected 0000", c, gnt); end
      step();
      n_checks++; if (odata !== 8'hA5 || src !== 2'd1 || valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b src=%0d d=%h expected v=1 src=1 d=a5", c, valid, src, odata); end
    end
    ready = 1'b1;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL stall_release_gnt: got %b expected 0100", gnt); end
    step();
    n_checks++; if (src !== 2'd2 || odata !== 8'h33) begin n_fail++; $display("FAIL stall_release_load: got src=%0d d=%h expected src=2 d=33", src, odata); end
    req = 4'b0000;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", valid); end
    ready = 1'b0; req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL empty_not_ready_gnt: got %b expected 0001", gnt); end
    step();
    n_checks++; if (valid !== 1'b1 || src !== 2'd0) begin n_fail++; $display("FAIL empty_not_ready_load: got v=%b src=%0d expected v=1 src=0", valid, src); end
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL full_not_ready_gnt: got %b expected 0000", gnt); end
    data = DATA_DEF; ready = 1'b1; req = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0001;
    do_reset();
    ready = 1'b1; data = DATA_DEF; req = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup_gnt: got %b expected 0100", gnt); end
    step();
    req = 4'b1010;
    #1;
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_win3_gnt: got %b expected 1000", gnt); end
    step();
    n_checks++; if (src !== 2'd3 || odata !== 8'h44) begin n_fail++; $display("FAIL wrap_win3_load: got src=%0d d=%h expected src=3 d=44", src, odata); end
    req = 4'b0010;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wrap_win1_gnt: got %b expected 0010", gnt); end
    step();
    n_checks++; if (src !== 2'd1 || odata !== 8'h22) begin n_fail++; $display("FAIL wrap_win1_load: got src=%0d d=%h expected src=1 d=22", src, odata); end
    // Client 1 has used one grant of its burst, so three more precede rotation to 0.
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL wrap_burst_gnt[%0d]: got %b expected %b", c, gnt, exp_seq[c]); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b1; data = DATA_DEF; req = 4'b1111;
    repeat (5) step();
    n_checks++; if (valid !== 1'b1 || src !== 2'd1) begin n_fail++; $display("FAIL mid_pre: got v=%b src=%0d expected v=1 src=1", valid, src); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", valid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt: got %b expected 0000", gnt); end
    n_checks++; if (odata !== 8'h00) begin n_fail++; $display("FAIL mid_data: got %h expected 00", odata); end
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_release_gnt: got %b expected 0001", gnt); end
    step();
    n_checks++; if (src !== 2'd0 || odata !== 8'h11) begin n_fail++; $display("FAIL mid_release_load: got src=%0d d=%h expected src=0 d=11", src, odata); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    ready    = 1'b1;
    data     = DATA_DEF;
    #12;
    test_reset();
    test_rr_burst();
    test_single_client();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
